// File: rtl/mem_model_types.sv
// Shared types for the data-memory responder: FSM state and latched request.
package mem_model_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmr_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        read;
    logic        write;
  } dmr_req_t;

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane merge: each enabled lane takes the new byte, others keep the old one.
module byte_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_be,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) o_merged[8*i +: 8] = i_new[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder for the datapath data port; replaces the single-cycle magic memory.
module data_mem_responder
  import mem_model_types::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  LOAD  = 4'(LATENCY - 1);

  dmr_state_t    r_state;
  dmr_state_t    w_nextState;
  logic [3:0]    r_count;
  logic [3:0]    w_nextCount;
  dmr_req_t      r_req;
  logic          w_accept;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_offset;
  logic          w_inRange;
  logic          w_err;
  logic [AW-1:0] w_index;
  logic [31:0]   w_oldWord;
  logic [31:0]   w_merged;
  logic          w_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      if (w_accept) begin
        r_req <= '{addr: mem_address, wdata: mem_wdata, be: mem_byte_enable,
                   read: mem_read, write: mem_write};
      end
    end
  end

  // Inputs are only looked at in IDLE; BUSY and RESP work purely from the latched request.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read | mem_write) begin
          w_accept    = 1'b1;
          w_nextCount = LOAD;
          w_nextState = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        w_nextCount = r_count - 4'd1;
        if (r_count == 4'd1) w_nextState = RESP;
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The offset wraps for addresses below the base, hence the separate lower-bound compare.
  assign w_offset  = r_req.addr - BASE_ADDR;
  assign w_inRange = (r_req.addr >= BASE_ADDR) && ({1'b0, w_offset} < LIMIT);
  assign w_index   = w_offset[AW+1:2];
  assign w_err     = ~w_inRange | (r_req.read & r_req.write);
  assign w_oldWord = r_mem[w_index];
  assign w_commit  = (r_state == RESP) & r_req.write & ~w_err;

  byte_merge u_merge (
    .i_old    (w_oldWord),
    .i_new    (r_req.wdata),
    .i_be     (r_req.be),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst && w_commit) r_mem[w_index] <= w_merged;
  end

  assign mem_resp  = (r_state == RESP);
  assign mem_err   = mem_resp & w_err;
  assign mem_rdata = (mem_resp & r_req.read & ~w_err) ? w_oldWord : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;
  import mem_model_types::*;

  localparam int          DEPTH     = 1024;
  localparam int          LATENCY   = 2;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE_ADDR(BASE_ADDR)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word array indexed by byte offset / 4, out-of-range or read+write is an error.
  task automatic predict(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int when);
    exp_t   e;
    longint off;
    bit     ok;
    int     idx;
    off = longint'(addr) - longint'(BASE_ADDR);
    ok  = (off >= 0) && (off < longint'(DEPTH) * 4) && !(rd && wr);
    idx = ok ? int'(off / 4) : 0;
    e.cyc   = when;
    e.err   = !ok;
    e.chk   = rd || !ok;
    e.rdata = (ok && rd) ? model[idx] : 32'h0;
    if (ok && wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
    end
    q.push_back(e);
  endtask

  task automatic driveIdle();
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'h0;
    mem_address = 32'h0; mem_wdata = 32'h0;
  endtask

  task automatic waitResp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_resp && n < 50);
    if (!mem_resp) checkOutput("resp_timeout", 32'(mem_resp), 32'h1);
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the edge ending RESP.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    predict(rd, wr, addr, wdata, be, cyc + LATENCY);
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wdata; mem_byte_enable = be;
    waitResp();
    @(posedge clk); #1;
    driveIdle();
  endtask

  initial begin
    int c;
    int r;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    rst = 1'b1;
    driveIdle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_resp", 32'(mem_resp), 32'h0);
    checkOutput("reset_err", 32'(mem_err), 32'h0);
    checkOutput("reset_rdata", mem_rdata, 32'h0);
    checkOutput("reset_state", 32'(dut.r_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (mem_resp) begin
          if (q.size() == 0) begin
            checkOutput("unexpected_resp", 32'(mem_resp), 32'h0);
          end else begin
            e = q.pop_front();
            checkOutput("resp_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("resp_err", 32'(mem_err), 32'(e.err));
            if (e.chk) checkOutput("resp_rdata", mem_rdata, e.rdata);
          end
        end else begin
          checkOutput("idle_rdata", mem_rdata, 32'h0);
          if (q.size() > 0 && cyc >= q[0].cyc) begin
            checkOutput("missing_resp", 32'(mem_resp), 32'h1);
            void'(q.pop_front());
          end
        end
      end
    join_none

    for (int w = 0; w < 256; w++) applyStimulus(1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF);

    applyStimulus(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h00AA0000, 4'b0100);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h00000055, 4'b0001);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 32'h104, 32'h11223344, 4'b0000);
    applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);

    // Hold mem_read across the whole access and retarget the address during BUSY.
    c = cyc;
    predict(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, c + LATENCY);
    predict(1'b1, 1'b0, 32'h108, 32'h0, 4'h0, c + 2 * LATENCY + 1);
    mem_read = 1'b1; mem_address = 32'h104;
    @(posedge clk); #1;
    mem_address = 32'h108;
    waitResp();
    waitResp();
    @(posedge clk); #1;
    driveIdle();

    applyStimulus(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h0000, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h0FFC, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 32'h200, 32'h12345678, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);

    // Abort a write with reset while BUSY: no response, no commit.
    mem_write = 1'b1; mem_address = 32'h300; mem_wdata = 32'hCAFEF00D; mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    driveIdle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_state", 32'(dut.r_state), 32'(IDLE));
    checkOutput("abort_resp", 32'(mem_resp), 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);

    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 99));
      a = {22'h0, 8'($urandom), 2'($urandom)};
      if (r < 8) a = 32'h1000 + 32'($urandom_range(0, 4095));
      if (r < 3) a = $urandom | 32'h0001_0000;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (r < 5)       applyStimulus(1'b1, 1'b1, a, $urandom, 4'($urandom));
      else if (r < 52) applyStimulus(1'b1, 1'b0, a, $urandom, 4'($urandom));
      else             applyStimulus(1'b0, 1'b1, a, $urandom, 4'($urandom));
    end

    repeat (6) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
